reg_bank_arbiter: RTL and testbench

- Shares one bank of DEPTH signed BUS_WIDTH-bit enable registers between NUM_REQ write requesters.
- Grants one writer per cycle using round-robin order. A requester may lock the bank for bounded bursts.
- Provides one combinational read port for the downstream datapath (filter coefficients, line/pixel staging).
- Sits between the requesting control FSMs and the register storage.

---
 rtl/reg_bank_pkg.sv | 43 ++++
 rtl/reg_bank_arbiter_en_reg.sv | 18 +
 rtl/reg_bank_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the arbitrated register bank.
package reg_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam int MAX_REQ       = 8;
    localparam int REQ_IDX_MAX_W = 3;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot winner: first set request scanning ptr, ptr+1, ... modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]       req,
        input logic [REQ_IDX_MAX_W-1:0] ptr,
        input int                       n
    );
        logic [MAX_REQ-1:0] pick;
        int                 idx;
        pick = '0;
        // Walk backwards so the closest requester to ptr is written last.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[2:0]]) begin
                    pick            = '0;
                    pick[idx[2:0]]  = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_en_reg.sv
// Enable register: loads d when en is high, clears on reset.
module reg_bank_arbiter_en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: bank storage is reset because downstream reads it before any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter with burst lock in front of a bank of enable registers.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int  BUS_WIDTH = 8,
    parameter int  NUM_REQ   = 4,
    parameter int  DEPTH     = 8,
    parameter int  MAX_BURST = 4,
    localparam int ADDR_W    = addr_width(DEPTH),
    localparam int IDX_W     = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  wr_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [IDX_W-1:0]              gnt_id,
    output logic                          locked,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic signed [BUS_WIDTH-1:0]   rd_data
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [BC_W-1:0]      cnt_q, cnt_d;

    logic [MAX_REQ-1:0]   req_ext, pick;
    logic [IDX_W-1:0]     scan_ptr, win_id;
    logic                 hold, win_valid, grant;
    logic [ADDR_W-1:0]    win_addr;
    logic [BUS_WIDTH-1:0] win_data;
    logic [BUS_WIDTH-1:0] bank_q [DEPTH];
    logic                 rst_n;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // NOTE: every comb output gets a default first so no latch can be inferred.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        hold                   = (state_q == OWN) && req[owner_q];
        // A releasing owner is skipped by starting the scan just past it.
        scan_ptr               = (state_q == OWN) ? next_idx(owner_q) : ptr_q;
        pick                   = rr_pick(req_ext, REQ_IDX_MAX_W'(scan_ptr), NUM_REQ);
        win_id                 = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) win_id = IDX_W'(i);
        end
        win_valid              = |pick;
        if (hold) begin
            win_id    = owner_q;
            win_valid = 1'b1;
        end
        grant    = win_valid && !rst;
        win_addr = wr_addr[win_id*ADDR_W +: ADDR_W];
        win_data = wr_data[win_id*BUS_WIDTH +: BUS_WIDTH];

        gnt = '0;
        if (grant) gnt[win_id] = 1'b1;
        gnt_id = grant ? win_id : '0;
        locked = !rst && (state_q == OWN);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (hold) begin
            cnt_d = cnt_q + BC_W'(1);
            if (!lock[owner_q] || (int'(cnt_q) + 1 == MAX_BURST)) begin
                state_d = IDLE;
                ptr_d   = next_idx(owner_q);
                cnt_d   = '0;
            end
        end else if (win_valid) begin
            ptr_d = next_idx(win_id);
            if (lock[win_id] && MAX_BURST > 1) begin
                state_d = OWN;
                owner_d = win_id;
                cnt_d   = BC_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == OWN) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rst_n = ~rst;

    for (genvar j = 0; j < DEPTH; j++) begin : g_bank
        logic we;
        // Out-of-range addresses match no entry, so the write is dropped.
        assign we = grant && (int'(win_addr) == j);
        reg_bank_arbiter_en_reg #(.WIDTH(BUS_WIDTH)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (we),
            .d     (win_data),
            .q     (bank_q[j])
        );
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? bank_q[rd_addr] : '0;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: directed grant sequences and bank readback.
module tb_reg_bank_arbiter;

    localparam int BW = 8;
    localparam int NR = 4;
    localparam int DP = 6;
    localparam int MB = 4;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, lock;
    logic [NR*AW-1:0]  wr_addr;
    logic [NR*BW-1:0]  wr_data;
    logic [NR-1:0]     gnt;
    logic [1:0]        gnt_id;
    logic              locked;
    logic [AW-1:0]     rd_addr;
    logic [BW-1:0]     rd_data;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [1:0]    id;
        logic          locked;
    } exp_t;

    exp_t        sb[$];
    logic [BW-1:0] exp_bank [DP];
    int          n_tests = 0;
    int          n_fail  = 0;

    reg_bank_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR), .DEPTH(DP), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .locked  (locked),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [NR-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*BW +: BW] = d;
    endtask

    // Drive one cycle of requests, queue the expectation, compare at the falling edge.
    task automatic expect_cycle(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] l,
                                input logic [NR-1:0] eg, input logic el);
        exp_t e, o;
        req      = r;
        lock     = l;
        e.gnt    = eg;
        e.id     = idx_of(eg);
        e.locked = el;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check({tag, ".gnt"},    32'(gnt),    32'(o.gnt));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(o.id));
        check({tag, ".locked"}, 32'(locked), 32'(o.locked));
    endtask

    task automatic beat(input string tag, input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic [NR-1:0] eg, input logic el);
        expect_cycle(tag, r, l, eg, el);
        @(posedge clk);
        #1;
    endtask

    // Only called while the arbiter is idle or in reset; spends one clock with no requests.
    task automatic check_bank(input string tag);
        req  = '0;
        lock = '0;
        for (int j = 0; j < DP; j++) begin
            rd_addr = AW'(j);
            #1;
            check($sformatf("%s.bank%0d", tag, j), 32'(rd_data), 32'(exp_bank[j]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        lock    = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NR; i++) set_wr(i, 3'd7, 8'hEE);
        for (int j = 0; j < DP; j++) exp_bank[j] = '0;

        // Reset holds grants off even with every requester active.
        expect_cycle("rst", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        check_bank("rst");
        rst = 1'b0;
        beat("rr0", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        beat("rr1", 4'b1111, 4'b0000, 4'b0010, 1'b0);
        beat("rr2", 4'b1111, 4'b0000, 4'b0100, 1'b0);
        beat("rr3", 4'b1111, 4'b0000, 4'b1000, 1'b0);
        beat("rr4", 4'b1111, 4'b0000, 4'b0001, 1'b0);

        // Single writer: -3 into entry 5.
        set_wr(2, 3'd5, 8'hFD);
        beat("single", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        exp_bank[5] = 8'hFD;
        check_bank("single");

        // Bring the pointer to 1, then a locked burst from 1 competing with 3.
        beat("align", 4'b0001, 4'b0000, 4'b0001, 1'b0);
        set_wr(1, 3'd1, 8'h11);
        set_wr(3, 3'd0, 8'h30);
        beat("burst1", 4'b1010, 4'b0010, 4'b0010, 1'b0);
        beat("burst2", 4'b1010, 4'b0010, 4'b0010, 1'b1);
        beat("burst3", 4'b1010, 4'b0010, 4'b0010, 1'b1);
        beat("burst4", 4'b1010, 4'b0010, 4'b0010, 1'b1);
        beat("burst5", 4'b1010, 4'b0010, 4'b1000, 1'b0);
        exp_bank[1] = 8'h11;
        exp_bank[0] = 8'h30;
        check_bank("burst");

        // Owner 0 drops its request mid-burst; requester 2 is granted in the same cycle.
        set_wr(0, 3'd2, 8'h22);
        set_wr(2, 3'd3, 8'h33);
        beat("rel1", 4'b0101, 4'b0001, 4'b0001, 1'b0);
        beat("rel2", 4'b0101, 4'b0001, 4'b0001, 1'b1);
        beat("rel3", 4'b0100, 4'b0001, 4'b0100, 1'b1);
        beat("rel4", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        exp_bank[2] = 8'h22;
        exp_bank[3] = 8'h33;
        check_bank("release");

        // Out-of-range address: grant issued, bank untouched, out-of-range reads give 0.
        set_wr(3, 3'd7, 8'h55);
        beat("oor", 4'b1000, 4'b0000, 4'b1000, 1'b0);
        check_bank("oor");
        rd_addr = 3'd7;
        #1;
        check("oor.rd7", 32'(rd_data), 32'h0);
        rd_addr = 3'd6;
        #1;
        check("oor.rd6", 32'(rd_data), 32'h0);

        // Reset during beat 2 of a locked burst.
        set_wr(1, 3'd4, 8'h44);
        beat("mb1", 4'b0010, 4'b0010, 4'b0010, 1'b0);
        expect_cycle("mb2", 4'b0010, 4'b0010, 4'b0010, 1'b1);
        set_wr(1, 3'd4, 8'h66);
        #1;
        rst = 1'b1;
        #1;
        check("mbrst.gnt",    32'(gnt),    32'h0);
        check("mbrst.gnt_id", 32'(gnt_id), 32'h0);
        check("mbrst.locked", 32'(locked), 32'h0);
        for (int j = 0; j < DP; j++) exp_bank[j] = '0;
        check_bank("mbrst");
        rst = 1'b0;
        beat("post0", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        beat("post1", 4'b1111, 4'b0000, 4'b0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
